// File: rtl/regfile_scanner_pkg.sv
// Shared definitions for the register-file scanner.
// Register indices follow the slice select bit order.
package regfile_scanner_pkg;

   localparam int NREGS = 14;
   localparam int IDX_W = 4;

   localparam logic [IDX_W-1:0] REG_PC  = 4'd0;
   localparam logic [IDX_W-1:0] REG_IR  = 4'd1;
   localparam logic [IDX_W-1:0] REG_WZ  = 4'd2;
   localparam logic [IDX_W-1:0] REG_SP  = 4'd3;
   localparam logic [IDX_W-1:0] REG_IY  = 4'd4;
   localparam logic [IDX_W-1:0] REG_IX  = 4'd5;
   localparam logic [IDX_W-1:0] REG_HL1 = 4'd6;
   localparam logic [IDX_W-1:0] REG_HL0 = 4'd7;
   localparam logic [IDX_W-1:0] REG_DE1 = 4'd8;
   localparam logic [IDX_W-1:0] REG_DE0 = 4'd9;
   localparam logic [IDX_W-1:0] REG_BC1 = 4'd10;
   localparam logic [IDX_W-1:0] REG_BC0 = 4'd11;
   localparam logic [IDX_W-1:0] REG_AF1 = 4'd12;
   localparam logic [IDX_W-1:0] REG_AF0 = 4'd13;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      DRIVE,
      SAMPLE,
      PRESENT,
      DONE
   } scan_state_t;

   function automatic logic [NREGS-1:0] reg_onehot(
      input logic [IDX_W-1:0] idx
   );
      return {{(NREGS-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/regfile_scanner.sv
// Debug reader for the register-file slice array.
// Walks every register select and streams each word out.
module regfile_scanner #(
   parameter int SLICES = 16,
   parameter int NREGS  = 14
) (
   input  logic              eclk,
   input  logic              erst_n,
   input  logic              start,
   input  logic              hold_ack,
   input  logic [SLICES-1:0] reg_dout,
   input  logic              out_ready,
   output logic              hold_req,
   output logic [NREGS-1:0]  sel,
   output logic              r_p,
   output logic              pc_wr,
   output logic              reg_wr,
   output logic              out_valid,
   output logic [SLICES-1:0] out_data,
   output logic [3:0]        out_idx,
   output logic              busy,
   output logic              abort
);
   import regfile_scanner_pkg::*;

   scan_state_t       state;
   scan_state_t       state_d;
   logic [3:0]        idx;
   logic [3:0]        idx_d;
   logic              hold_ack_q;
   logic              owned;
   logic              lost;

   logic              hold_req_d;
   logic [NREGS-1:0]  sel_d;
   logic              r_p_d;
   logic              out_valid_d;
   logic [SLICES-1:0] out_data_d;
   logic [3:0]        out_idx_d;
   logic              busy_d;
   logic              abort_d;

   assign pc_wr  = 1'b0;
   assign reg_wr = 1'b0;

   // Losing the grant while owning (or just granted) kills the scan.
   assign owned = state inside {DRIVE, SAMPLE, PRESENT};
   assign lost  = (owned && !hold_ack) ||
                  (state == REQ && hold_ack_q && !hold_ack);

   always_ff @(posedge eclk) begin
      if (!erst_n) begin
         state      <= IDLE;
         idx        <= '0;
         hold_ack_q <= 1'b0;
         hold_req   <= 1'b0;
         sel        <= '0;
         r_p        <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_idx    <= '0;
         busy       <= 1'b0;
         abort      <= 1'b0;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         hold_ack_q <= hold_ack;
         hold_req   <= hold_req_d;
         sel        <= sel_d;
         r_p        <= r_p_d;
         out_valid  <= out_valid_d;
         out_data   <= out_data_d;
         out_idx    <= out_idx_d;
         busy       <= busy_d;
         abort      <= abort_d;
      end
   end

   always_comb begin
      state_d = state;
      idx_d   = idx;
      if (lost) begin
         state_d = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  state_d = REQ;
                  idx_d   = '0;
               end
            end
            REQ: begin
               if (hold_ack) state_d = DRIVE;
            end
            DRIVE:  state_d = SAMPLE;
            SAMPLE: state_d = PRESENT;
            PRESENT: begin
               if (out_ready) begin
                  if (idx == REG_AF0) begin
                     state_d = DONE;
                  end else begin
                     idx_d   = idx + 4'd1;
                     state_d = DRIVE;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are registered, so they are decoded from the next state.
   always_comb begin
      hold_req_d  = state_d inside {REQ, DRIVE, SAMPLE, PRESENT};
      sel_d       = '0;
      r_p_d       = state_d inside {DRIVE, SAMPLE, PRESENT};
      out_valid_d = state_d == PRESENT;
      out_data_d  = out_data;
      out_idx_d   = out_idx;
      busy_d      = state_d != IDLE;
      abort_d     = lost;
      if (state_d inside {DRIVE, SAMPLE}) begin
         sel_d = reg_onehot(idx_d);
      end
      if (state == SAMPLE && state_d == PRESENT) begin
         out_data_d = reg_dout;
         out_idx_d  = idx;
      end
   end

endmodule
